// File: rtl/qspi_flash_avmm.sv
// Avalon-MM slave to serial NOR flash engine: word reads become fast-read
// transactions, word writes become WREN + page program. Optional macro QSPI_WIP_POLL_EN.
`timescale 1ns/1ps
module qspi_flash_avmm #(
  parameter int          AW           = 22,
  parameter int          DW           = 32,
  parameter int          SPI_W        = 4,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          CLK_DIV      = 2,
  parameter logic [7:0]  RD_CMD       = 8'h6B,
  parameter logic [7:0]  WR_CMD       = 8'h32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [AW-1:0]     address,
  input  logic              read,
  input  logic              write,
  input  logic [DW-1:0]     writedata,
  input  logic [DW/8-1:0]   byteenable,
  output logic              waitrequest,
  output logic [DW-1:0]     readdata,
  output logic              readdatavalid,
  output logic              idle,
  output logic              SCK,
  output logic              CSn,
  input  logic [SPI_W-1:0]  MISO,
  output logic [SPI_W-1:0]  MOSI,
  output logic              mosi_oe
);

  localparam int DVW = $clog2(CLK_DIV) + 1;
  localparam int GW  = $clog2(4 * CLK_DIV + 2) + 1;
  localparam int PL  = (SPI_W > 1) ? 1 : 0;
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_CS   = GW'(4 * CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_DONE = GW'(4 * CLK_DIV + 1);
  localparam logic [7:0]     NB_DATA  = 8'(32 / SPI_W);
  localparam logic [7:0]     NB_DUMMY = 8'(DUMMY_CYCLES);

  typedef enum logic [3:0] {
    IDLE, WREN, GAP, CMD, ADDR, DUMMY, DATA, POLL, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DVW-1:0]   div_q, div_d;
  logic             sck_q, sck_d;
  logic [7:0]       bits_q, bits_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      rx_q, rx_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             wr_q, wr_d;
  logic             pend_q, pend_d;
  logic             poll_q, poll_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdv_q, rdv_d;
  logic             csn_q, csn_d;
  logic             oe_q, oe_d;
  logic [SPI_W-1:0] mosi_q, mosi_d;
  logic             wait_q, wait_d;
  logic             idle_q, idle_d;

  logic             shifting, last;
  logic [AW+25:0]   addr_ext;
  logic [23:0]      fa;
  logic [31:0]      wmap;

  assign addr_ext = {24'h0, address, 2'b00};
  assign fa       = addr_ext[23:0];
  // Stream order: flash byte A+0 first; disabled bytes become FF so the flash cell is untouched.
  assign wmap = {byteenable[0] ? writedata[7:0]   : 8'hFF,
                 byteenable[1] ? writedata[15:8]  : 8'hFF,
                 byteenable[2] ? writedata[23:16] : 8'hFF,
                 byteenable[3] ? writedata[31:24] : 8'hFF};

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    bits_d   = bits_q;
    gap_d    = gap_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    wr_d     = wr_q;
    pend_d   = pend_q;
    poll_d   = poll_q;
    rdata_d  = rdata_q;
    rdv_d    = 1'b0;
    last     = 1'b0;
    shifting = (state_q inside {WREN, CMD, ADDR, DUMMY, DATA, POLL});

    // Every phase ends on an SCK fall, so the next phase starts with SCK low and div at zero.
    if (shifting) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          if (state_q == DATA && !wr_q) rx_d = {rx_q[31-SPI_W:0], MISO};
          else if (state_q == POLL)     rx_d = {rx_q[30:0], MISO[PL]};
        end else begin
          sck_d  = 1'b0;
          sh_d   = (state_q == DATA) ? (sh_q << SPI_W) : (sh_q << 1);
          bits_d = bits_q - 8'd1;
          last   = (bits_q == 8'd1);
        end
      end else begin
        div_d = div_q + DVW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          wr_d    = 1'b1;
          state_d = WREN;
          sh_d    = {8'h06, 24'h0};
          bits_d  = 8'd8;
        end else if (read) begin
          state_d = CMD;
          wr_d    = 1'b0;
          addr_d  = fa;
          sh_d    = {RD_CMD, 24'h0};
          bits_d  = 8'd8;
          if (write && (|byteenable)) begin
            pend_d = 1'b1;
            wdat_d = wmap;
          end
        end else if (write && (|byteenable)) begin
          state_d = WREN;
          wr_d    = 1'b1;
          addr_d  = fa;
          wdat_d  = wmap;
          sh_d    = {8'h06, 24'h0};
          bits_d  = 8'd8;
        end
      end
      WREN: if (last) begin
        state_d = GAP;
        gap_d   = GAP_CS;
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = CMD;
          sh_d    = {WR_CMD, 24'h0};
          bits_d  = 8'd8;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      CMD: if (last) begin
        state_d = ADDR;
        sh_d    = {addr_q, 8'h00};
        bits_d  = 8'd24;
      end
      ADDR: if (last) begin
        if (wr_q || DUMMY_CYCLES == 0) begin
          state_d = DATA;
          sh_d    = wr_q ? wdat_q : '0;
          bits_d  = NB_DATA;
        end else begin
          state_d = DUMMY;
          sh_d    = '0;
          bits_d  = NB_DUMMY;
        end
      end
      DUMMY: if (last) begin
        state_d = DATA;
        sh_d    = '0;
        bits_d  = NB_DATA;
      end
      DATA: if (last) begin
        state_d = DONE;
        gap_d   = GAP_DONE;
`ifdef QSPI_WIP_POLL_EN
        poll_d  = wr_q;
`else
        poll_d  = 1'b0;
`endif
      end
      POLL: if (last) begin
        state_d = DONE;
        gap_d   = GAP_DONE;
        poll_d  = rx_q[0];
      end
      DONE: begin
        if (gap_q == '0) begin
          if (poll_q) begin
            state_d = POLL;
            sh_d    = {8'h05, 24'h0};
            bits_d  = 8'd16;
          end else begin
            state_d = IDLE;
            if (!wr_q) begin
              rdv_d   = 1'b1;
              rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered from next-state values so CSn, SCK and MOSI move together.
    csn_d  = !(state_d inside {WREN, CMD, ADDR, DUMMY, DATA, POLL});
    oe_d   = (state_d inside {WREN, CMD, ADDR}) || (state_d == DATA && wr_d) ||
             (state_d == POLL && bits_d > 8'd8);
    mosi_d = '0;
    if (state_d == DATA) begin
      if (wr_d) mosi_d = sh_d[31 -: SPI_W];
    end else if (oe_d) begin
      mosi_d[0] = sh_d[31];
    end
    wait_d = !(state_d == IDLE && !pend_d);
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      bits_q  <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      poll_q  <= 1'b0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      csn_q   <= 1'b1;
      oe_q    <= 1'b0;
      mosi_q  <= '0;
      wait_q  <= 1'b1;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      bits_q  <= bits_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      poll_q  <= poll_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      csn_q   <= csn_d;
      oe_q    <= oe_d;
      mosi_q  <= mosi_d;
      wait_q  <= wait_d;
      idle_q  <= idle_d;
    end
  end

  assign waitrequest   = wait_q;
  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign idle          = idle_q;
  assign SCK           = sck_q;
  assign CSn           = csn_q;
  assign MOSI          = mosi_q;
  assign mosi_oe       = oe_q;

endmodule

// File: tb/tb_qspi_flash_avmm.sv
// Scoreboard bench for qspi_flash_avmm: flash pin model decodes each CSn frame,
// read-data monitor checks readdata and latency against queued expectations.
`timescale 1ns/1ps
module tb_qspi_flash_avmm;
  localparam int AW      = 22;
  localparam int SPI_W   = 4;
  localparam int DUMMY   = 8;
  localparam int CLK_DIV = 2;
  localparam int RD_LAT  = (8 + 24 + DUMMY + 32 / SPI_W) * (2 * CLK_DIV) + 4 * CLK_DIV + 2;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [AW-1:0]    address = '0;
  logic             read = 1'b0, write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [3:0]       byteenable = '0;
  logic             waitrequest, readdatavalid, idle, SCK, CSn, mosi_oe;
  logic [31:0]      readdata;
  logic [SPI_W-1:0] MOSI;
  logic [SPI_W-1:0] miso_r;

  always #5 aclk = ~aclk;

  qspi_flash_avmm #(.AW(AW), .DW(32), .SPI_W(SPI_W), .DUMMY_CYCLES(DUMMY), .CLK_DIV(CLK_DIV),
                    .RD_CMD(8'h6B), .WR_CMD(8'h32)) dut (
    .aclk(aclk), .aresetn(aresetn), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .idle(idle), .SCK(SCK), .CSn(CSn),
    .MISO(miso_r), .MOSI(MOSI), .mosi_oe(mosi_oe));

  typedef struct { logic [7:0] cmd; logic [23:0] addr; logic [31:0] data; int nsck; } tx_t;
  typedef struct { logic [31:0] data; int acc; } rd_t;
  tx_t exp_tx[$];
  rd_t exp_rd[$];
  int  n_chk = 0, n_fail = 0;
  int  cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- flash pin model ----------------
  logic [3:0]  cap_mosi [0:63];
  logic        cap_oe   [0:63];
  int          nsck = 0;
  logic [7:0]  cur_cmd = '0;
  logic [23:0] cur_addr = '0;
  logic [31:0] rd_word = '0;
  logic [7:0]  stat;
  int          poll_cnt = 0;
  time         t_rise = 0;
  bit          seen_rise = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000400: return 8'h11;
      24'h000401: return 8'h22;
      24'h000402: return 8'h33;
      24'h000403: return 8'h44;
      default:    return 8'hFF;
    endcase
  endfunction

  assign stat = (poll_cnt < 3) ? 8'h01 : 8'h00;

  always @* begin
    miso_r = '0;
    if (cur_cmd == 8'h6B && nsck >= 40 && nsck < 48)
      miso_r = rd_word[31 - 4 * (nsck - 40) -: 4];
    else if (cur_cmd == 8'h05 && nsck >= 8 && nsck < 16)
      miso_r[1] = stat[15 - nsck];
  end

  always @(negedge CSn) begin
    nsck    = 0;
    cur_cmd = '0;
    if (seen_rise) chk("csn_gap_ge8", (($time - t_rise) / 10 >= 8) ? 1 : 0, 1);
  end

  always @(posedge SCK) begin
    if (!CSn) begin
      logic [7:0] c;
      if (nsck < 64) begin
        cap_mosi[nsck] = MOSI;
        cap_oe[nsck]   = mosi_oe;
      end
      nsck++;
      if (nsck == 8) begin
        c = '0;
        for (int i = 0; i < 8; i++) c = {c[6:0], cap_mosi[i][0]};
        cur_cmd = c;
      end
      if (nsck == 32) begin
        cur_addr = '0;
        for (int i = 8; i < 32; i++) cur_addr = {cur_addr[22:0], cap_mosi[i][0]};
        rd_word = {mem_byte(cur_addr), mem_byte(cur_addr + 24'd1),
                   mem_byte(cur_addr + 24'd2), mem_byte(cur_addr + 24'd3)};
      end
    end
  end

  always @(posedge CSn) begin
    logic [7:0]  cmd;
    logic [23:0] ad;
    logic [31:0] dt;
    logic        oe_ok, eo;
    tx_t         e;
    t_rise    = $time;
    seen_rise = 1'b1;
    if (aresetn) begin
      cmd = '0; ad = '0; dt = '0; oe_ok = 1'b1;
      for (int i = 0; i < 8; i++) cmd = {cmd[6:0], cap_mosi[i][0]};
      if (cmd == 8'h6B || cmd == 8'h32)
        for (int i = 8; i < 32; i++) ad = {ad[22:0], cap_mosi[i][0]};
      if (cmd == 8'h32)
        for (int i = 32; i < 40; i++) dt = {dt[27:0], cap_mosi[i]};
      for (int k = 0; k < nsck && k < 64; k++) begin
        case (cmd)
          8'h05:   eo = (k < 8);
          8'h6B:   eo = (k < 32);
          default: eo = 1'b1;
        endcase
        if (cap_oe[k] !== eo) oe_ok = 1'b0;
      end
      if (cmd == 8'h05) poll_cnt++;
      if (cmd == 8'h06) poll_cnt = 0;
      if (exp_tx.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_tx: got cmd %0h expected no transaction", cmd);
      end else begin
        e = exp_tx.pop_front();
        chk("tx_cmd",  cmd, e.cmd);
        chk("tx_addr", ad, e.addr);
        chk("tx_data", dt, e.data);
        chk("tx_nsck", nsck, e.nsck);
        chk("tx_mosi_oe", oe_ok, 1);
      end
      #1 chk("tx_end_sck_low", SCK, 0);
    end
  end

  // ---------------- read-data monitor ----------------
  always @(negedge aclk) begin
    if (aresetn && readdatavalid) begin
      rd_t r;
      if (exp_rd.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rdv: got readdata %0h expected no strobe", readdata);
      end else begin
        r = exp_rd.pop_front();
        chk("readdata", readdata, r.data);
        chk("read_latency", cyc - r.acc, RD_LAT);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_tx(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d, input int n);
    tx_t t;
    t.cmd = c; t.addr = a; t.data = d; t.nsck = n;
    exp_tx.push_back(t);
  endtask

  task automatic exp_write(input logic [23:0] a, input logic [31:0] stream);
    push_tx(8'h06, 24'h0, 32'h0, 8);
    push_tx(8'h32, a, stream, 8 + 24 + 32 / SPI_W);
`ifdef QSPI_WIP_POLL_EN
    for (int i = 0; i < 4; i++) push_tx(8'h05, 24'h0, 32'h0, 16);
`endif
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int acc);
    @(negedge aclk);
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    for (int i = 0; i < 2000 && waitrequest; i++) @(negedge aclk);
    chk("accept_wait", waitrequest, 0);
    acc = cyc + 1;
    @(negedge aclk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge aclk);
    while (waitrequest && i < 5000) begin
      @(negedge aclk);
      i++;
    end
    #2;
    chk({name, "_done_wait"}, waitrequest, 0);
    chk({name, "_txq_empty"}, exp_tx.size(), 0);
    chk({name, "_rdq_empty"}, exp_rd.size(), 0);
  endtask

  initial begin
    int   acc;
    int   lowcnt;
    rd_t  r;
    repeat (10) @(negedge aclk);
    chk("rst_csn", CSn, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_wait", waitrequest, 1);
    chk("rst_idle", idle, 0);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_oe", mosi_oe, 0);
    chk("rst_mosi", MOSI, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_wait", waitrequest, 0);
    chk("rel_idle", idle, 1);

    // x4 fast read of word 0x100 (byte 0x400)
    push_tx(8'h6B, 24'h000400, 32'h0, 48);
    issue(1'b1, 1'b0, 22'h000100, 32'h0, 4'h0, acc);
    r.data = 32'h44332211; r.acc = acc; exp_rd.push_back(r);
    wait_idle("rd1");

    // partial write: bytes 5A FF A5 FF
    exp_write(24'h000000, 32'h5AFFA5FF);
    issue(1'b0, 1'b1, 22'h0, 32'hA5A55A5A, 4'b0101, acc);
    wait_idle("wr1");

    // byteenable 0000: acknowledged without touching the flash
    issue(1'b0, 1'b1, 22'h000003, 32'hDEADBEEF, 4'b0000, acc);
    #2;
    chk("be0_wait", waitrequest, 0);
    chk("be0_idle", idle, 1);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!CSn) lowcnt++;
    end
    chk("be0_no_access", lowcnt, 0);

    // read and write together: read first, then the write with no re-request
    push_tx(8'h6B, 24'h000400, 32'h0, 48);
    exp_write(24'h000400, 32'h78563412);
    issue(1'b1, 1'b1, 22'h000100, 32'h12345678, 4'hF, acc);
    r.data = 32'h44332211; r.acc = acc; exp_rd.push_back(r);
    wait_idle("rdwr");

    // reset in the middle of the address phase
    issue(1'b1, 1'b0, 22'h000100, 32'h0, 4'h0, acc);
    repeat (44) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("abort_csn", CSn, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_wait", waitrequest, 1);
    repeat (10) @(negedge aclk);
    chk("abort_rdv", readdatavalid, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("abort_rel_wait", waitrequest, 0);
    chk("abort_rel_idle", idle, 1);

    push_tx(8'h6B, 24'h000400, 32'h0, 48);
    issue(1'b1, 1'b0, 22'h000100, 32'h0, 4'h0, acc);
    r.data = 32'h44332211; r.acc = acc; exp_rd.push_back(r);
    wait_idle("rd2");

    repeat (20) @(negedge aclk);
    chk("end_txq_empty", exp_tx.size(), 0);
    chk("end_rdq_empty", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_chk++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
